// File: rtl/aclk_bcd_time_counter.sv
// ---------------------------------------------------------------------------
// aclk_bcd_time_counter
//
// Alarm-clock time-of-day counter. Time is stored as registered 24-hour BCD
// digits. The count advances on a one-cycle tick pulse, and a load port can
// overwrite it.
//
// Parameters
//   SEC_EN  : 1 = HH:MM:SS, tick is one second.
//             0 = HH:MM, tick is one minute and the seconds logic is removed.
//   HR12_EN : 1 = mode_12h selects a 12-hour hour display.
//             0 = mode_12h is ignored and the display is always 24-hour.
//
// Ports
//   clk                     : clock. All state changes on its rising edge.
//   reset                   : asynchronous reset, active low.
//   tick                    : one-cycle advance pulse.
//   load_new_c              : load request for the new_current_time_* digits.
//   mode_12h                : display-mode select. Affects the display only.
//   new_current_time_*      : BCD load value, always given in 24-hour form.
//   current_time_*          : BCD time. The hour is shown in 12h form when
//                             that mode is active.
//   pm                      : 1 while the 24-hour hour is 12..23.
//   day_rollover            : one-cycle pulse on the 23:59(:59) -> 00:00 wrap.
//   load_err                : one-cycle pulse when a load request is rejected.
// ---------------------------------------------------------------------------
module aclk_bcd_time_counter #(
    parameter int SEC_EN  = 1,
    parameter int HR12_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load_new_c,
    input  logic       mode_12h,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    input  logic [3:0] new_current_time_ms_sec,
    input  logic [3:0] new_current_time_ls_sec,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic [3:0] current_time_ms_sec,
    output logic [3:0] current_time_ls_sec,
    output logic       pm,
    output logic       day_rollover,
    output logic       load_err
);

    localparam bit SEC_ON  = (SEC_EN  != 32'sd0);
    localparam bit HR12_ON = (HR12_EN != 32'sd0);

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Range check of a load request. The seconds digits are checked only
    // when a seconds counter exists.
    function automatic logic load_is_valid(
        input logic [3:0] h1,
        input logic [3:0] h0,
        input logic [3:0] m1,
        input logic [3:0] m0,
        input logic [3:0] s1,
        input logic [3:0] s0,
        input logic       chk_sec
    );
        logic ok;
        ok = (h1 <= 4'd2) && (h0 <= 4'd9) && !((h1 == 4'd2) && (h0 > 4'd3)) &&
             (m1 <= 4'd5) && (m0 <= 4'd9);
        if (chk_sec) begin
            ok = ok && (s1 <= 4'd5) && (s0 <= 4'd9);
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    // Next hour in BCD. 23 wraps to 00 and ls 9 carries into ms.
    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h23) begin
            r = 8'h00;
        end else if (h[3:0] == 4'd9) begin
            r = {h[7:4] + 4'd1, 4'd0};
        end else begin
            r = {h[7:4], h[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD ordering matches numeric ordering for valid digits, so a plain
    // magnitude compare against 0x12 gives the PM flag.
    function automatic logic hour_is_pm(input logic [7:0] h);
        return (h >= 8'h12);
    endfunction

    // Convert a 24-hour BCD hour to its 12-hour display form.
    function automatic logic [7:0] hour_to_12h(input logic [7:0] h);
        logic [7:0] r;
        case (h)
            8'h00:   r = 8'h12;
            8'h13:   r = 8'h01;
            8'h14:   r = 8'h02;
            8'h15:   r = 8'h03;
            8'h16:   r = 8'h04;
            8'h17:   r = 8'h05;
            8'h18:   r = 8'h06;
            8'h19:   r = 8'h07;
            8'h20:   r = 8'h08;
            8'h21:   r = 8'h09;
            8'h22:   r = 8'h10;
            8'h23:   r = 8'h11;
            default: r = h;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State and control
    // -----------------------------------------------------------------------
    logic [3:0] ms_hr_r, ls_hr_r, ms_min_r, ls_min_r;
    logic [3:0] ms_sec_r, ls_sec_r;
    logic [3:0] ms_hr_nxt_s, ls_hr_nxt_s, ms_min_nxt_s, ls_min_nxt_s;
    logic       pm_r, day_rollover_r, load_err_r;

    logic       load_ok_s;       // accepted load this cycle
    logic       load_bad_s;      // rejected load this cycle
    logic       adv_s;           // tick not shadowed by a load
    logic       sec_wrap_s;      // seconds at :59 (always 1 without seconds)
    logic       min_step_s;      // advance ls_min this cycle
    logic       hr_step_s;       // advance the hour this cycle
    logic       day_wrap_s;      // 23:59(:59) -> 00:00 this cycle
    logic [7:0] hr_disp_s;

    // Load qualification and carry chain. A load always wins over a tick.
    always_comb begin
        load_ok_s  = load_new_c && load_is_valid(
                         new_current_time_ms_hr, new_current_time_ls_hr,
                         new_current_time_ms_min, new_current_time_ls_min,
                         new_current_time_ms_sec, new_current_time_ls_sec,
                         SEC_ON);
        load_bad_s = load_new_c && !load_ok_s;
        adv_s      = tick && !load_new_c;
        min_step_s = adv_s && sec_wrap_s;
        hr_step_s  = min_step_s && (ms_min_r == 4'd5) && (ls_min_r == 4'd9);
        day_wrap_s = hr_step_s && (ms_hr_r == 4'd2) && (ls_hr_r == 4'd3);
    end

    // Next-state of hour and minute digits.
    always_comb begin
        ms_hr_nxt_s  = ms_hr_r;
        ls_hr_nxt_s  = ls_hr_r;
        ms_min_nxt_s = ms_min_r;
        ls_min_nxt_s = ls_min_r;
        if (load_ok_s) begin
            ms_hr_nxt_s  = new_current_time_ms_hr;
            ls_hr_nxt_s  = new_current_time_ls_hr;
            ms_min_nxt_s = new_current_time_ms_min;
            ls_min_nxt_s = new_current_time_ls_min;
        end else if (min_step_s) begin
            if (ls_min_r == 4'd9) begin
                ls_min_nxt_s = 4'd0;
                if (ms_min_r == 4'd5) begin
                    ms_min_nxt_s = 4'd0;
                    {ms_hr_nxt_s, ls_hr_nxt_s} = hour_inc({ms_hr_r, ls_hr_r});
                end else begin
                    ms_min_nxt_s = ms_min_r + 4'd1;
                end
            end else begin
                ls_min_nxt_s = ls_min_r + 4'd1;
            end
        end else begin
            ls_min_nxt_s = ls_min_r;
        end
    end

    // Hour/minute registers and the registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_hr_r        <= 4'd0;
            ls_hr_r        <= 4'd0;
            ms_min_r       <= 4'd0;
            ls_min_r       <= 4'd0;
            pm_r           <= 1'b0;
            day_rollover_r <= 1'b0;
            load_err_r     <= 1'b0;
        end else begin
            ms_hr_r        <= ms_hr_nxt_s;
            ls_hr_r        <= ls_hr_nxt_s;
            ms_min_r       <= ms_min_nxt_s;
            ls_min_r       <= ls_min_nxt_s;
            pm_r           <= hour_is_pm({ms_hr_nxt_s, ls_hr_nxt_s});
            day_rollover_r <= day_wrap_s;
            load_err_r     <= load_bad_s;
        end
    end

    // -----------------------------------------------------------------------
    // Seconds counter, present only when SEC_EN is set
    // -----------------------------------------------------------------------
    if (SEC_ON) begin : gen_sec
        logic [3:0] ms_sec_nxt_s, ls_sec_nxt_s;

        // Next-state of the seconds digits.
        always_comb begin
            ms_sec_nxt_s = ms_sec_r;
            ls_sec_nxt_s = ls_sec_r;
            if (load_ok_s) begin
                ms_sec_nxt_s = new_current_time_ms_sec;
                ls_sec_nxt_s = new_current_time_ls_sec;
            end else if (adv_s) begin
                if (ls_sec_r == 4'd9) begin
                    ls_sec_nxt_s = 4'd0;
                    ms_sec_nxt_s = (ms_sec_r == 4'd5) ? 4'd0 : ms_sec_r + 4'd1;
                end else begin
                    ls_sec_nxt_s = ls_sec_r + 4'd1;
                end
            end else begin
                ls_sec_nxt_s = ls_sec_r;
            end
        end

        // Seconds registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ms_sec_r <= 4'd0;
                ls_sec_r <= 4'd0;
            end else begin
                ms_sec_r <= ms_sec_nxt_s;
                ls_sec_r <= ls_sec_nxt_s;
            end
        end

        assign sec_wrap_s = (ms_sec_r == 4'd5) && (ls_sec_r == 4'd9);
    end else begin : gen_no_sec
        logic unused_sec_s;

        // Each tick is a minute, so the minute digit steps on every tick.
        assign sec_wrap_s   = 1'b1;
        assign ms_sec_r     = 4'd0;
        assign ls_sec_r     = 4'd0;
        assign unused_sec_s = ^{new_current_time_ms_sec, new_current_time_ls_sec};
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------

    // The hour display is combinational from the registered hour, so a mode
    // change shows up with no latency and never touches the count.
    always_comb begin
        if (HR12_ON && mode_12h) begin
            hr_disp_s = hour_to_12h({ms_hr_r, ls_hr_r});
        end else begin
            hr_disp_s = {ms_hr_r, ls_hr_r};
        end
    end

    assign current_time_ms_hr  = hr_disp_s[7:4];
    assign current_time_ls_hr  = hr_disp_s[3:0];
    assign current_time_ms_min = ms_min_r;
    assign current_time_ls_min = ls_min_r;
    assign current_time_ms_sec = ms_sec_r;
    assign current_time_ls_sec = ls_sec_r;
    assign pm                  = pm_r;
    assign day_rollover        = day_rollover_r;
    assign load_err            = load_err_r;

endmodule

// File: tb/tb_aclk_bcd_time_counter.sv
module tb_aclk_bcd_time_counter;

    logic       clk;
    logic       reset;
    logic       tick, load_new_c, mode_12h;
    logic [3:0] n_ms_hr, n_ls_hr, n_ms_min, n_ls_min, n_ms_sec, n_ls_sec;
    logic [3:0] c_ms_hr, c_ls_hr, c_ms_min, c_ls_min, c_ms_sec, c_ls_sec;
    logic       pm, day_rollover, load_err;

    logic       m_tick, m_load;
    logic [3:0] mn_ms_hr, mn_ls_hr, mn_ms_min, mn_ls_min;
    logic [3:0] mc_ms_hr, mc_ls_hr, mc_ms_min, mc_ls_min, mc_ms_sec, mc_ls_sec;
    logic       m_pm, m_dr, m_le;

    logic [26:0] obs, m_obs;

    typedef struct {
        string       name;
        logic [26:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    aclk_bcd_time_counter #(.SEC_EN(1), .HR12_EN(1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load_new_c(load_new_c),
        .mode_12h(mode_12h),
        .new_current_time_ms_hr(n_ms_hr), .new_current_time_ls_hr(n_ls_hr),
        .new_current_time_ms_min(n_ms_min), .new_current_time_ls_min(n_ls_min),
        .new_current_time_ms_sec(n_ms_sec), .new_current_time_ls_sec(n_ls_sec),
        .current_time_ms_hr(c_ms_hr), .current_time_ls_hr(c_ls_hr),
        .current_time_ms_min(c_ms_min), .current_time_ls_min(c_ls_min),
        .current_time_ms_sec(c_ms_sec), .current_time_ls_sec(c_ls_sec),
        .pm(pm), .day_rollover(day_rollover), .load_err(load_err)
    );

    aclk_bcd_time_counter #(.SEC_EN(0), .HR12_EN(1)) dut_m (
        .clk(clk), .reset(reset), .tick(m_tick), .load_new_c(m_load),
        .mode_12h(1'b0),
        .new_current_time_ms_hr(mn_ms_hr), .new_current_time_ls_hr(mn_ls_hr),
        .new_current_time_ms_min(mn_ms_min), .new_current_time_ls_min(mn_ls_min),
        .new_current_time_ms_sec(4'd0), .new_current_time_ls_sec(4'd0),
        .current_time_ms_hr(mc_ms_hr), .current_time_ls_hr(mc_ls_hr),
        .current_time_ms_min(mc_ms_min), .current_time_ls_min(mc_ls_min),
        .current_time_ms_sec(mc_ms_sec), .current_time_ls_sec(mc_ls_sec),
        .pm(m_pm), .day_rollover(m_dr), .load_err(m_le)
    );

    assign obs   = {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min, c_ms_sec, c_ls_sec,
                    pm, day_rollover, load_err};
    assign m_obs = {mc_ms_hr, mc_ls_hr, mc_ms_min, mc_ls_min, mc_ms_sec, mc_ls_sec,
                    m_pm, m_dr, m_le};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observation; value shown as time digits then pm/dr/le.
    task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h pm/dr/le=%b, expected %h pm/dr/le=%b",
                     nm, act[26:3], act[2:0], exp[26:3], exp[2:0]);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge state.
    task automatic step(input string nm, input logic t, input logic ld, input logic md,
                        input logic [23:0] nt, input logic [23:0] et, input logic [2:0] ef);
        exp_t e;
        @(negedge clk);
        tick       = t;
        load_new_c = ld;
        mode_12h   = md;
        {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min, n_ms_sec, n_ls_sec} = nt;
        e.name = nm;
        e.val  = {et, ef};
        sb_q.push_back(e);
        @(posedge clk);
        #2;
        tick       = 1'b0;
        load_new_c = 1'b0;
    endtask

    // Monitor: after every edge, compare the DUT against the next expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, obs, e.val);
        end
    end

    // Minute-only instance: one load or tick per cycle, checked after the edge.
    task automatic m_step(input string nm, input logic t, input logic ld,
                          input logic [15:0] nt, input logic [26:0] exp);
        @(negedge clk);
        m_tick = t;
        m_load = ld;
        {mn_ms_hr, mn_ls_hr, mn_ms_min, mn_ls_min} = nt;
        @(posedge clk);
        #1;
        check(nm, m_obs, exp);
        m_tick = 1'b0;
        m_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        tick = 1'b0; load_new_c = 1'b0; mode_12h = 1'b0;
        {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min, n_ms_sec, n_ls_sec} = 24'h000000;
        m_tick = 1'b0; m_load = 1'b0;
        {mn_ms_hr, mn_ls_hr, mn_ms_min, mn_ls_min} = 16'h0000;
        #2;
        check("reset_state", obs, {24'h000000, 3'b000});
        @(negedge clk);
        reset = 1'b1;

        step("load_142237", 1'b0, 1'b1, 1'b0, 24'h142237, 24'h142237, 3'b100);

        // Asynchronous reset mid-count, checked before any clock edge.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("rst_async", obs, {24'h000000, 3'b000});
        mode_12h = 1'b1;
        #1 check("rst_12h", obs, {24'h120000, 3'b000});
        tick = 1'b1; load_new_c = 1'b1;
        {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min, n_ms_sec, n_ls_sec} = 24'h111111;
        @(posedge clk);
        #1 check("rst_hold_edge", obs, {24'h120000, 3'b000});
        @(negedge clk);
        tick = 1'b0; load_new_c = 1'b0; mode_12h = 1'b0;
        reset = 1'b1;

        step("post_rst_idle",  1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000);
        step("load_235859",    1'b0, 1'b1, 1'b0, 24'h235859, 24'h235859, 3'b100);
        step("tick_235900",    1'b1, 1'b0, 1'b0, 24'h000000, 24'h235900, 3'b100);
        step("load_235959",    1'b0, 1'b1, 1'b0, 24'h235959, 24'h235959, 3'b100);
        step("tick_day_wrap",  1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b010);
        step("tick_000001",    1'b1, 1'b0, 1'b0, 24'h000000, 24'h000001, 3'b000);
        step("load_100000",    1'b0, 1'b1, 1'b0, 24'h100000, 24'h100000, 3'b000);
        step("bad_hr24",       1'b0, 1'b1, 1'b0, 24'h240000, 24'h100000, 3'b001);
        step("bad_min60",      1'b0, 1'b1, 1'b0, 24'h126000, 24'h100000, 3'b001);
        step("bad_sec60",      1'b0, 1'b1, 1'b0, 24'h100060, 24'h100000, 3'b001);
        step("bad_hr0a",       1'b0, 1'b1, 1'b0, 24'h0a0000, 24'h100000, 3'b001);
        step("bad_load_tick",  1'b1, 1'b1, 1'b0, 24'h250000, 24'h100000, 3'b001);
        step("idle_no_err",    1'b0, 1'b0, 1'b0, 24'h000000, 24'h100000, 3'b000);
        step("load_with_tick", 1'b1, 1'b1, 1'b0, 24'h071530, 24'h071530, 3'b000);
        step("tick_071531",    1'b1, 1'b0, 1'b0, 24'h000000, 24'h071531, 3'b000);
        step("tick_071532",    1'b1, 1'b0, 1'b0, 24'h000000, 24'h071532, 3'b000);
        step("load_1305_12h",  1'b0, 1'b1, 1'b1, 24'h130500, 24'h010500, 3'b100);
        step("load_0045_12h",  1'b0, 1'b1, 1'b1, 24'h004500, 24'h124500, 3'b000);
        step("load_1200_12h",  1'b0, 1'b1, 1'b1, 24'h120000, 24'h120000, 3'b100);
        step("load_195959",    1'b0, 1'b1, 1'b0, 24'h195959, 24'h195959, 3'b100);
        step("tick_hr_carry",  1'b1, 1'b0, 1'b0, 24'h000000, 24'h200000, 3'b100);
        step("mode_flip_20",   1'b0, 1'b0, 1'b1, 24'h000000, 24'h080000, 3'b100);
        step("load_095959",    1'b0, 1'b1, 1'b0, 24'h095959, 24'h095959, 3'b000);
        step("tick_100000",    1'b1, 1'b0, 1'b0, 24'h000000, 24'h100000, 3'b000);
        step("load_1159_12h",  1'b0, 1'b1, 1'b1, 24'h115959, 24'h115959, 3'b000);
        step("tick_noon_12h",  1'b1, 1'b0, 1'b1, 24'h000000, 24'h120000, 3'b100);
        step("tick_hold_12h",  1'b1, 1'b0, 1'b1, 24'h000000, 24'h120001, 3'b100);

        @(negedge clk);
        mode_12h = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        // Minute-only instance.
        m_step("m_load_0959",  1'b0, 1'b1, 16'h0959, {24'h095900, 3'b000});
        m_step("m_tick_1000",  1'b1, 1'b0, 16'h0000, {24'h100000, 3'b000});
        m_step("m_tick_1001",  1'b1, 1'b0, 16'h0000, {24'h100100, 3'b000});
        m_step("m_load_2359",  1'b0, 1'b1, 16'h2359, {24'h235900, 3'b100});
        m_step("m_tick_wrap",  1'b1, 1'b0, 16'h0000, {24'h000000, 3'b010});
        m_step("m_bad_2400",   1'b0, 1'b1, 16'h2400, {24'h000000, 3'b001});
        m_step("m_idle",       1'b0, 1'b0, 16'h0000, {24'h000000, 3'b000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
